// File: rtl/pipe_pkt_sequencer.sv
// pipe_pkt_sequencer: per-packet run controller for the pipeline CPU and its packet FIFO.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_run_en, i_sw_load     software run enable, instruction-load mode (aborts activity)
//   i_fifo_full             FIFO holds a complete packet
//   i_data_processed        CPU completion strobe
//   i_drain_done            FIFO output side has emptied the packet
//   o_cpu_run, o_cpu_flush  instruction counter enable, pipeline flush
//   o_fifo_connect          route FIFO to the output port
//   o_timeout_err           sticky watchdog-abort flag
//   o_state                 FSM state for the status register
//   o_pkt_count, o_timeout_count, o_last_cycles  statistics
module pipe_pkt_sequencer #(
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FLUSH_CYCLES   = 3,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run_en,
    input  logic                 i_sw_load,
    input  logic                 i_fifo_full,
    input  logic                 i_data_processed,
    input  logic                 i_drain_done,
    output logic                 o_cpu_run,
    output logic                 o_cpu_flush,
    output logic                 o_fifo_connect,
    output logic                 o_timeout_err,
    output logic [2:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_pkt_count,
    output logic [15:0]          o_timeout_count,
    output logic [CNT_WIDTH-1:0] o_last_cycles
);
    typedef enum logic [2:0] {IDLE = 3'd0, WAIT_PKT = 3'd1, FLUSH = 3'd2, RUN = 3'd3, DRAIN = 3'd4} state_t;
    localparam logic [3:0]               FLUSH_LAST  = 4'(FLUSH_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_VAL = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
    state_t                   r_state;
    state_t                   w_next;
    logic [3:0]               r_flush_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_cyc;
    logic                     w_done;
    logic                     w_timeout;
    logic                     w_drained;
    assign o_state = r_state;
    always_comb begin
        // sw_load outranks every per-state event, so statistics are gated by it too
        w_done    = !i_sw_load && r_state == RUN && i_data_processed;
        w_timeout = !i_sw_load && r_state == RUN && !i_data_processed && r_cyc == TIMEOUT_VAL;
        w_drained = !i_sw_load && r_state == DRAIN && i_drain_done;
        w_next    = r_state;
        if (i_sw_load)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:     w_next = i_run_en ? WAIT_PKT : IDLE;
                WAIT_PKT: w_next = !i_run_en ? IDLE : (i_fifo_full ? FLUSH : WAIT_PKT);
                FLUSH:    w_next = r_flush_cnt == FLUSH_LAST ? RUN : FLUSH;
                RUN:      w_next = (w_done || w_timeout) ? DRAIN : RUN;
                DRAIN:    w_next = w_drained ? (i_run_en ? WAIT_PKT : IDLE) : DRAIN;
                default:  w_next = IDLE;
            endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_flush_cnt     <= '0;
            r_cyc           <= '0;
            o_cpu_run       <= 1'b0;
            o_cpu_flush     <= 1'b0;
            o_fifo_connect  <= 1'b0;
            o_timeout_err   <= 1'b0;
            o_pkt_count     <= '0;
            o_timeout_count <= '0;
            o_last_cycles   <= '0;
        end else begin
            r_state        <= w_next;
            // controls are decoded from the next state so they line up with o_state
            o_cpu_run      <= w_next == RUN;
            o_cpu_flush    <= w_next == FLUSH;
            o_fifo_connect <= w_next == DRAIN;
            r_flush_cnt    <= (r_state == FLUSH && w_next == FLUSH) ? r_flush_cnt + 4'd1 : 4'd0;
            // cycle count reads 1 during the first RUN cycle
            r_cyc          <= w_next != RUN ? '0 : (r_state == RUN ? r_cyc + TIMEOUT_WIDTH'(1) : TIMEOUT_WIDTH'(1));
            if (w_done)
                o_last_cycles <= CNT_WIDTH'(r_cyc);
            if (w_timeout) begin
                o_last_cycles <= CNT_WIDTH'(TIMEOUT_CYCLES);
                o_timeout_err <= 1'b1;
                if (o_timeout_count != 16'hFFFF)
                    o_timeout_count <= o_timeout_count + 16'd1;
            end
            if (r_state == IDLE && w_next == WAIT_PKT)
                o_timeout_err <= 1'b0;
            if (w_drained)
                o_pkt_count <= o_pkt_count + CNT_WIDTH'(1);
        end
    end
endmodule
